// File: rtl/mux2_arbiter_pkg.sv
// Shared definitions for the two-source round-robin mux arbiter: FSM
// encodings and the sizing helper for the stall/timeout counter.
package mux2_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    // Counter must be able to hold TIMEOUT itself without wrapping.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mux2_arbiter_mux2.sv
// One-bit 2:1 mux cell; the arbiter stamps out one per datapath bit.
module mux2_arbiter_mux2 (
    input  logic a_i,
    input  logic b_i,
    input  logic s_i,
    output logic y_o
);
    assign y_o = s_i ? b_i : a_i;
endmodule

// File: rtl/mux2_arbiter.sv
// Round-robin arbiter steering two packet sources onto one output channel.
// A grant is held until the owner's last beat is accepted or it stalls out.
module mux2_arbiter
    import mux2_arbiter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             last0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             last1,
    input  logic             out_ready,
    output logic             gnt0,
    output logic             gnt1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             timeout_err
);
    localparam int            CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic          prio_q, prio_d;
    logic          sel_q, sel_d;
    logic [CW-1:0] idle_cnt_q, idle_cnt_d;
    logic          granted, accept, done, tmo;
    logic [WIDTH:0] mux_a, mux_b, mux_y;

    // Datapath: last rides along as the top bit so it is steered with the data.
    assign mux_a = {last0, data0};
    assign mux_b = {last1, data1};
    for (genvar j = 0; j <= WIDTH; j++) begin : g_mux
        mux2_arbiter_mux2 u_mux (
            .a_i (mux_a[j]),
            .b_i (mux_b[j]),
            .s_i (sel_q),
            .y_o (mux_y[j])
        );
    end
    assign out_data = mux_y[WIDTH-1:0];
    assign out_last = mux_y[WIDTH];
    assign sel      = sel_q;

    assign granted   = (state_q != IDLE);
    assign out_valid = (gnt0 & req0) | (gnt1 & req1);
    assign accept    = out_valid & out_ready;
    assign done      = accept & out_last;
    assign tmo       = granted & ~out_valid & (idle_cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            sel_q      <= 1'b0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            sel_q      <= sel_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

    // Release on done or stall; hand straight to the other source if it is waiting.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        case (state_q)
            IDLE: begin
                if (req0 && req1) state_d = prio_q ? OWN1 : OWN0;
                else if (req0)    state_d = OWN0;
                else if (req1)    state_d = OWN1;
            end
            OWN0: begin
                if (done || tmo) begin
                    prio_d  = 1'b1;
                    state_d = req1 ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (done || tmo) begin
                    prio_d  = 1'b0;
                    state_d = req0 ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        sel_d = sel_q;
        if (state_d == OWN0)      sel_d = 1'b0;
        else if (state_d == OWN1) sel_d = 1'b1;

        idle_cnt_d = idle_cnt_q;
        if (state_d != state_q || out_valid)  idle_cnt_d = '0;
        else if (granted && idle_cnt_q != '1) idle_cnt_d = idle_cnt_q + CW'(1);
    end

    always_comb begin
        gnt0        = (state_q == OWN0);
        gnt1        = (state_q == OWN1);
        busy        = (state_q != IDLE);
        timeout_err = tmo;
    end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a
// transaction-level model of ownership, priority and stall counting.
module tb_mux2_arbiter;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst, req0, last0, req1, last1, out_ready;
    logic [WIDTH-1:0] data0, data1;
    logic             gnt0, gnt1, sel, out_valid, out_last, busy, timeout_err;
    logic [WIDTH-1:0] out_data;

    int checks = 0;
    int errors = 0;

    // Model: owner is -1 when nobody holds the channel.
    int m_owner, m_prio, m_sel, m_idle;
    bit m_known = 0;
    logic te_seen;

    always #5 clk = ~clk;

    mux2_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .last0(last0),
        .req1(req1), .data1(data1), .last1(last1),
        .out_ready(out_ready),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, compare against the model, then advance both.
    task automatic step(input logic r, input logic q0, input logic [WIDTH-1:0] d0, input logic l0,
                        input logic q1, input logic [WIDTH-1:0] d1, input logic l1, input logic rdy);
        logic [1:0] rq, lt;
        logic vld, acc_last, tmo_e;
        int other;
        rst = r; req0 = q0; data0 = d0; last0 = l0;
        req1 = q1; data1 = d1; last1 = l1; out_ready = rdy;
        rq = {q1, q0};
        lt = {l1, l0};
        #3;
        vld      = (m_owner >= 0) && rq[m_owner];
        acc_last = vld && rdy && lt[m_owner];
        tmo_e    = (m_owner >= 0) && !vld && (m_idle == TIMEOUT - 1);
        te_seen  = timeout_err;
        if (m_known) begin
            chk("gnt0", gnt0, m_owner == 0);
            chk("gnt1", gnt1, m_owner == 1);
            chk("sel", sel, m_sel);
            chk("busy", busy, m_owner >= 0);
            chk("out_valid", out_valid, vld);
            chk("out_data", out_data, m_sel ? d1 : d0);
            chk("out_last", out_last, m_sel ? l1 : l0);
            chk("timeout_err", timeout_err, tmo_e);
        end
        if (r) begin
            m_owner = -1; m_prio = 0; m_sel = 0; m_idle = 0; m_known = 1;
        end else if (m_owner < 0) begin
            if (q0 && q1)  m_owner = m_prio;
            else if (q0)   m_owner = 0;
            else if (q1)   m_owner = 1;
            if (m_owner >= 0) m_sel = m_owner;
            m_idle = 0;
        end else if (acc_last || tmo_e) begin
            other   = 1 - m_owner;
            m_prio  = other;
            m_owner = rq[other] ? other : -1;
            if (m_owner >= 0) m_sel = m_owner;
            m_idle = 0;
        end else if (vld) begin
            m_idle = 0;
        end else if (m_idle < TIMEOUT) begin
            m_idle++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; last0 = 0; last1 = 0;
        data0 = '0; data1 = '0; out_ready = 0;
        @(posedge clk);
        #1;

        // 1: reset with both requests high
        step(1, 1, 8'h11, 0, 1, 8'h22, 0, 1);
        step(1, 1, 8'h11, 0, 1, 8'h22, 0, 1);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);

        // 2: single source, three beats
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(0, 1, 8'hA5, 0, 0, 8'h00, 0, 1);
        chk("single_gnt0", gnt0, 1);
        step(0, 1, 8'hA5, 0, 0, 8'h00, 0, 1);
        step(0, 1, 8'hA5, 0, 0, 8'h00, 0, 1);
        step(0, 1, 8'hA5, 1, 0, 8'h00, 0, 1);
        chk("single_idle", busy, 0);

        // 3: tie out of reset, 2-beat packets, no bubble between owners
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(0, 1, 8'h01, 0, 1, 8'h02, 0, 1);
        chk("tie_first0", gnt0, 1);
        step(0, 1, 8'h01, 0, 1, 8'h02, 0, 1);
        step(0, 1, 8'h01, 1, 1, 8'h02, 0, 1);
        chk("tie_then1", gnt1, 1);
        step(0, 1, 8'h01, 0, 1, 8'h02, 0, 1);
        step(0, 1, 8'h01, 0, 1, 8'h02, 1, 1);
        chk("tie_back0", gnt0, 1);

        // 4: backpressure on source 1
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1, 8'h3C, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 8'h00, 0, 1, 8'h3C, 1, 0);
            chk("bp_hold", gnt1, 1);
        end
        step(0, 0, 8'h00, 0, 1, 8'h3C, 1, 1);
        chk("bp_release", busy, 0);

        // 5: source 1 stalls mid-packet; grant moves to source 0 after timeout
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(0, 0, 8'h00, 0, 1, 8'h77, 0, 1);
        step(0, 0, 8'h00, 0, 1, 8'h77, 0, 1);
        for (int i = 0; i < TIMEOUT; i++) begin
            step(0, 1, 8'h55, 0, 0, 8'h77, 0, 1);
            chk("tmo_pulse", te_seen, i == TIMEOUT - 1);
        end
        chk("tmo_gnt1", gnt1, 0);
        chk("tmo_gnt0", gnt0, 1);

        // 6: reset mid-packet, then tie goes to source 0
        step(1, 0, 8'h00, 0, 0, 8'h00, 0, 1);
        step(0, 1, 8'h10, 0, 1, 8'h20, 0, 1);
        step(0, 1, 8'h10, 0, 1, 8'h20, 0, 1);
        step(0, 1, 8'h10, 1, 1, 8'h20, 0, 1);
        step(1, 1, 8'h10, 0, 1, 8'h20, 0, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_sel", sel, 0);
        step(0, 1, 8'h10, 0, 1, 8'h20, 0, 1);
        chk("rstmid_tie0", gnt0, 1);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < 60, WIDTH'($urandom), $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 60, WIDTH'($urandom), $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 70);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
